// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 Hz timing for the VGA timing controller.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PhActive,
        PhFront,
        PhSync,
        PhBack
    } axis_phase_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_phase.sv
// Combinational decode of one axis counter into its active/front/sync/back phase.
module vga_axis_phase
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW     = 10,
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96
) (
    input  logic [CW-1:0] cnt,
    output axis_phase_t   phase
);

    localparam logic [CW-1:0] FRONT_START = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START  = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BACK_START  = CW'(ACTIVE + FP + SYNC);

    always_comb begin
        if (cnt < FRONT_START) begin
            phase = PhActive;
        end else if (cnt < SYNC_START) begin
            phase = PhFront;
        end else if (cnt < BACK_START) begin
            phase = PhSync;
        end else begin
            phase = PhBack;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel-rate enable, raster counters, syncs and blanking.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned PIX_DIV  = 2,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;

    axis_phase_t h_phase, v_phase;

    logic hsync_d, vsync_d, video_on_d, pix_tick_d, line_start_d, frame_start_d;

    vga_axis_phase #(
        .CW     (CW),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC)
    ) u_h_phase (
        .cnt   (h_cnt_q),
        .phase (h_phase)
    );

    vga_axis_phase #(
        .CW     (CW),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC)
    ) u_v_phase (
        .cnt   (v_cnt_q),
        .phase (v_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            video_on    <= video_on_d;
            x           <= h_cnt_q;
            y           <= v_cnt_q;
            pix_tick    <= pix_tick_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
        end
    end

    // The line counter only moves on the last clk of a pixel, the frame counter on a line wrap.
    always_comb begin
        div_cnt_d = div_cnt_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    always_comb begin
        pix_tick_d    = (div_cnt_q == '0);
        line_start_d  = pix_tick_d && (h_cnt_q == '0);
        frame_start_d = line_start_d && (v_cnt_q == '0);
        hsync_d       = (h_phase == PhSync) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (v_phase == PhSync) ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (h_phase == PhActive) && (v_phase == PhActive);
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default, small PIX_DIV=2 and small PIX_DIV=1/active-high instances.
module tb_vga_timing_ctrl;

    typedef struct {
        logic hs, vs, von, tick, ls, fs;
        int   x, y;
    } obs_t;

    typedef struct {
        int   ha, hf, hs, hb, va, vf, vs, vb, pd;
        logic pol;
    } cfg_t;

    typedef struct {
        logic rst;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       hs0, vs0, von0, tk0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, von1, tk1, ls1, fs1;
    logic [4:0] x1, y1;
    logic       hs2, vs2, von2, tk2, ls2, fs2;
    logic [3:0] x2, y2;

    vga_timing_ctrl u_dut0 (
        .clk(clk), .rst(rst), .hsync(hs0), .vsync(vs0), .video_on(von0), .x(x0), .y(y0),
        .pix_tick(tk0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .PIX_DIV(2), .SYNC_POL(1'b0), .CW(5)
    ) u_dut1 (
        .clk(clk), .rst(rst), .hsync(hs1), .vsync(vs1), .video_on(von1), .x(x1), .y(y1),
        .pix_tick(tk1), .line_start(ls1), .frame_start(fs1)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .PIX_DIV(1), .SYNC_POL(1'b1), .CW(4)
    ) u_dut2 (
        .clk(clk), .rst(rst), .hsync(hs2), .vsync(vs2), .video_on(von2), .x(x2), .y(y2),
        .pix_tick(tk2), .line_start(ls2), .frame_start(fs2)
    );

    int     checks = 0;
    int     failures = 0;
    longint age = -1;
    longint cyc = 0;
    cfg_t   cfg[3];
    vec_t   tbl[9];

    // Raster position follows directly from clks elapsed since reset release.
    function automatic obs_t model(cfg_t c, longint a);
        obs_t   o;
        longint ht, vt, p;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        if (a < 0) begin
            o.hs = ~c.pol; o.vs = ~c.pol; o.von = 1'b0;
            o.tick = 1'b0; o.ls = 1'b0; o.fs = 1'b0; o.x = 0; o.y = 0;
            return o;
        end
        p      = a / c.pd;
        o.x    = int'(p % ht);
        o.y    = int'((p / ht) % vt);
        o.tick = ((a % c.pd) == 0);
        o.ls   = o.tick && (o.x == 0);
        o.fs   = o.ls && (o.y == 0);
        o.hs   = (o.x >= c.ha + c.hf && o.x < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
        o.vs   = (o.y >= c.va + c.vf && o.y < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
        o.von  = (o.x < c.ha) && (o.y < c.va);
        return o;
    endfunction

    function automatic obs_t act(int d);
        obs_t o;
        case (d)
            0: begin
                o.hs = hs0; o.vs = vs0; o.von = von0; o.tick = tk0; o.ls = ls0; o.fs = fs0;
                o.x = int'(x0); o.y = int'(y0);
            end
            1: begin
                o.hs = hs1; o.vs = vs1; o.von = von1; o.tick = tk1; o.ls = ls1; o.fs = fs1;
                o.x = int'(x1); o.y = int'(y1);
            end
            default: begin
                o.hs = hs2; o.vs = vs2; o.von = von2; o.tick = tk2; o.ls = ls2; o.fs = fs2;
                o.x = int'(x2); o.y = int'(y2);
            end
        endcase
        return o;
    endfunction

    task automatic cmp_obs(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a.hs !== e.hs || a.vs !== e.vs || a.von !== e.von || a.tick !== e.tick ||
            a.ls !== e.ls || a.fs !== e.fs || a.x != e.x || a.y != e.y) begin
            failures++;
            $display("FAIL %s age=%0d got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b ls=%b fs=%b want x=%0d y=%0d hs=%b vs=%b von=%b tick=%b ls=%b fs=%b",
                     name, age, a.x, a.y, a.hs, a.vs, a.von, a.tick, a.ls, a.fs,
                     e.x, e.y, e.hs, e.vs, e.von, e.tick, e.ls, e.fs);
        end
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One clk: track elapsed clks since release, then compare every instance with the model.
    task automatic step();
        @(posedge clk);
        if (rst) age = -1;
        else     age++;
        cyc++;
        #1;
        for (int d = 0; d < 3; d++) begin
            cmp_obs($sformatf("model_dut%0d", d), act(d), model(cfg[d], age));
        end
    endtask

    function automatic obs_t mk(logic hs, logic vs, logic von, int xx, int yy,
                                logic tick, logic ls, logic fs);
        obs_t o;
        o.hs = hs; o.vs = vs; o.von = von; o.x = xx; o.y = yy;
        o.tick = tick; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    initial begin
        cfg[0] = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pd: 2, pol: 1'b0};
        cfg[1] = '{ha: 8, hf: 2, hs: 3, hb: 3, va: 5, vf: 1, vs: 2, vb: 2, pd: 2, pol: 1'b0};
        cfg[2] = '{ha: 6, hf: 1, hs: 2, hb: 3, va: 4, vf: 1, vs: 1, vb: 2, pd: 1, pol: 1'b1};

        // Reset held three clks, then release on the default instance.
        for (int i = 0; i < 3; i++) tbl[i] = '{rst: 1'b1, exp: mk(1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[3] = '{rst: 1'b0, exp: mk(1, 1, 1, 0, 0, 1, 1, 1)};
        tbl[4] = '{rst: 1'b0, exp: mk(1, 1, 1, 0, 0, 0, 0, 0)};
        tbl[5] = '{rst: 1'b0, exp: mk(1, 1, 1, 1, 0, 1, 0, 0)};
        tbl[6] = '{rst: 1'b0, exp: mk(1, 1, 1, 1, 0, 0, 0, 0)};
        tbl[7] = '{rst: 1'b0, exp: mk(1, 1, 1, 2, 0, 1, 0, 0)};
        tbl[8] = '{rst: 1'b0, exp: mk(1, 1, 1, 2, 0, 0, 0, 0)};

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst;
            step();
            cmp_obs($sformatf("table_%0d", i), act(0), tbl[i].exp);
        end

        // First line of the default raster: blanking, hsync window and line wrap.
        begin
            logic p_von, p_hs, done;
            int   p_x, low_clk;
            p_von = von0; p_hs = hs0; p_x = int'(x0); low_clk = 0; done = 1'b0;
            for (int n = 0; n < 2000 && !done; n++) begin
                step();
                if (hs0 == 1'b0) low_clk++;
                if (p_von && !von0) chk("von_fall_x", x0, 640);
                if (p_hs && !hs0) chk("hsync_fall_x", x0, 656);
                if (!p_hs && hs0) begin
                    chk("hsync_rise_x", x0, 752);
                    chk("hsync_low_clk", low_clk, 192);
                end
                if (p_x == 799 && x0 == 0) begin
                    chk("wrap_y", y0, 1);
                    chk("wrap_line_start", ls0, 1);
                    chk("wrap_frame_start", fs0, 0);
                    done = 1'b1;
                end
                p_von = von0; p_hs = hs0; p_x = int'(x0);
            end
            chk("line_wrap_seen", done, 1);
        end

        // Frame-level behaviour on the small instances.
        rst = 1'b1; step();
        rst = 1'b0;
        begin
            longint f1_last, f2_last, l2_last, vs_run;
            int     f1_cnt, blank_bad, edge_bad, tick_miss;
            logic   p_vs1;
            f1_last = -1; f2_last = -1; l2_last = -1; vs_run = 0;
            f1_cnt = 0; blank_bad = 0; edge_bad = 0; tick_miss = 0; p_vs1 = vs1;
            for (int n = 0; n < 700; n++) begin
                step();
                if (fs1) begin
                    if (f1_last >= 0) chk("frame_period_dut1", cyc - f1_last, 320);
                    f1_last = cyc; f1_cnt++;
                end
                if (fs2) begin
                    if (f2_last >= 0) chk("frame_period_dut2", cyc - f2_last, 96);
                    f2_last = cyc;
                end
                if (ls2) begin
                    if (l2_last >= 0 && n < 60) chk("line_period_dut2", cyc - l2_last, 12);
                    l2_last = cyc;
                end
                if (!tk2) tick_miss++;
                if (y1 >= 5 && von1) blank_bad++;
                if (vs1 != p_vs1 && x1 != 0) edge_bad++;
                if (!vs1) vs_run++;
                if (!p_vs1 && vs1) begin
                    chk("vsync_low_clk_dut1", vs_run, 64);
                    vs_run = 0;
                end
                p_vs1 = vs1;
            end
            chk("frame_pulses_dut1", f1_cnt, 3);
            chk("vblank_video_on", blank_bad, 0);
            chk("vsync_edge_at_x0", edge_bad, 0);
            chk("pix_tick_const_dut2", tick_miss, 0);
        end

        // Single-clk reset in the middle of a frame.
        begin
            logic found;
            found = 1'b0;
            for (int n = 0; n < 400 && !found; n++) begin
                step();
                if (x1 == 13 && y1 == 6) found = 1'b1;
            end
            chk("midframe_pos_found", found, 1);
            rst = 1'b1; step();
            cmp_obs("midframe_reset_dut1", act(1), mk(1, 1, 0, 0, 0, 0, 0, 0));
            cmp_obs("midframe_reset_dut2", act(2), mk(0, 0, 0, 0, 0, 0, 0, 0));
            rst = 1'b0; step();
            cmp_obs("midframe_release_dut1", act(1), mk(1, 1, 1, 0, 0, 1, 1, 1));
            step();
            cmp_obs("midframe_second_clk_dut1", act(1), mk(1, 1, 1, 0, 0, 0, 0, 0));
            cmp_obs("midframe_second_clk_dut2", act(2), mk(0, 0, 1, 1, 0, 1, 0, 0));
        end

        // Random reset pulses of random length against the model.
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
                rst = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
